inv_edge_meter: RTL

Downstream measurement stage for the CMOS inverter cell. It samples the inverter output (`sig_in`, asynchronous to `clk`), synchronises it and detects its edges, then counts the high time, low time and period in `clk` cycles. Results are published with a one-cycle `valid` strobe, either for a single period or continuously. The measured values are used to check inverter sizing and rise/fall balance against the 200-unit stimulus toggle.

---
 rtl/inv_meter_pkg.sv | 15 +
 rtl/sync_edge.sv | 36 +++
 rtl/inv_edge_meter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/inv_meter_pkg.sv
// Shared definitions for the inverter edge meter: FSM state encoding and
// default sizing of the counters and the input synchroniser.
package inv_meter_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } meter_state_e;

endpackage

// File: rtl/sync_edge.sv
// Synchroniser and edge detector for the asynchronous inverter output.
// Ports:
//   clk, rst_n   - clock and synchronous active-low reset
//   sig_in       - asynchronous input
//   rise, fall   - single-cycle edge flags of the synchronised level
// SYNC_STAGES must be 2 or more.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;

  // Shift chain; the last stage is the synchronised level, s_d_q its history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

endmodule

// File: rtl/inv_edge_meter.sv
// Measures high time, low time and period of the inverter output in clk
// cycles and publishes each completed period with a one-cycle valid strobe,
// single-shot or continuously.
// Ports:
//   clk, rst_n        - clock and synchronous active-low reset
//   sig_in            - asynchronous inverter output
//   start, cont, stop - arm request, continuous-mode select, leave continuous
//   busy              - meter not idle (held through the final valid cycle)
//   valid             - one-cycle strobe, results updated in the same cycle
//   high_cnt, low_cnt - measured high / low time, saturating
//   period            - high_cnt + low_cnt, one bit wider
//   ovf               - a counter saturated during the reported period
module inv_edge_meter
  import inv_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  input  logic             stop,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             rise;
  logic             fall;
  meter_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] h_q;
  logic             ovf_int_q;
  logic             cont_q;
  logic             stop_pend_q;
  logic             cnt_at_max;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign cnt_at_max = (cnt_q == CNT_MAX);

  // Measurement FSM with working counter and registered results.
  // The counter only runs while a level is being timed (HIGH/LOW), so a long
  // wait in ARM cannot flag a spurious overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      h_q         <= '0;
      ovf_int_q   <= 1'b0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      high_cnt    <= '0;
      low_cnt     <= '0;
      period      <= '0;
      ovf         <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (stop && (state_q != ST_IDLE)) begin
        stop_pend_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          // busy drops one cycle after the final report
          busy <= start;
          if (start) begin
            state_q   <= ST_ARM;
            cont_q    <= cont;
            ovf_int_q <= 1'b0;
          end
        end

        ST_ARM: begin
          busy <= 1'b1;
          if (rise) begin
            state_q <= ST_HIGH;
            cnt_q   <= CNT_W'(1);
          end
        end

        ST_HIGH: begin
          busy <= 1'b1;
          if (fall) begin
            state_q <= ST_LOW;
            h_q     <= cnt_q;
            cnt_q   <= CNT_W'(1);
          end else if (cnt_at_max) begin
            ovf_int_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_LOW: begin
          busy <= 1'b1;
          if (rise) begin
            valid    <= 1'b1;
            high_cnt <= h_q;
            low_cnt  <= cnt_q;
            period   <= (CNT_W+1)'(h_q) + (CNT_W+1)'(cnt_q);
            ovf      <= ovf_int_q;
            cnt_q    <= CNT_W'(1);
            // a stop arriving with the closing edge still ends the run here
            if (!cont_q || stop_pend_q || stop) begin
              state_q     <= ST_IDLE;
              stop_pend_q <= 1'b0;
            end else begin
              state_q   <= ST_HIGH;
              ovf_int_q <= 1'b0;
            end
          end else if (cnt_at_max) begin
            ovf_int_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
